spi_master_arbiter: RTL and testbench

- Sequences and shares one SPI master instance (config port, start/finish handshake, din/dout) among N_REQ requesters.
- Round-robin arbitration. For each granted request: load that requester's mode/width config, pulse start, wait for finish, return received word with a one-cycle ack.
- Sits between SoC-side clients (sensor pollers, flash loader) and the SPI master top.

---
 rtl/spi_arb_pkg.sv | 39 +++
 rtl/spi_rr_picker.sv | 38 +++
 rtl/spi_master_arbiter.sv | 159 +++++++++++++++
 tb/tb_spi_master_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// ============================================================
// spi_arb_pkg : shared states, widths and config field layout
// Rev 1.0
// ============================================================
`default_nettype none

package spi_arb_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CFG    = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  function automatic int cfg_w(input int width_log);
    return width_log + 2;
  endfunction

  function automatic int data_w(input int width_log);
    return 1 << width_log;
  endfunction

  // Config word layout: {cpol, cpha, spi_width}
  function automatic int cpol_bit(input int cw);
    return cw - 1;
  endfunction

  function automatic int cpha_bit(input int cw);
    return cw - 2;
  endfunction

  function automatic int width_msb(input int cw);
    return cw - 3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_rr_picker.sv
// ============================================================
// spi_rr_picker : combinational round-robin select from rr_ptr
// Rev 1.0
// ============================================================
`default_nettype none

module spi_rr_picker #(
  parameter int N_REQ = 2,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    rr_ptr_i,
  output logic             found_o,
  output logic [IW-1:0]    idx_o
);

  logic [IW:0] w_sum;

  // Scan offsets from highest to lowest so the smallest offset wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    w_sum   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, rr_ptr_i} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N_REQ)) begin
        w_sum = w_sum - (IW+1)'(N_REQ);
      end
      if (req_i[w_sum[IW-1:0]]) begin
        found_o = 1'b1;
        idx_o   = w_sum[IW-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_master_arbiter.sv
// ============================================================
// spi_master_arbiter : round-robin sharing of one SPI master
// Optional macro SPI_ARB_CFG_SKIP_EN skips CFG/SETTLE on repeated cfg
// Rev 1.0
// ============================================================
`default_nettype none

module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int SPI_MAX_WIDTH_LOG = 4,
  localparam int CW = cfg_w(SPI_MAX_WIDTH_LOG),
  localparam int DW = data_w(SPI_MAX_WIDTH_LOG),
  localparam int IW = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req_i,
  input  logic [N_REQ*CW-1:0] req_cfg_i,
  input  logic [N_REQ*DW-1:0] req_wdata_i,
  output logic [N_REQ-1:0]  ack_o,
  output logic [DW-1:0]     rdata_o,
  output logic              busy_o,
  output logic [IW-1:0]     grant_idx_o,
  output logic              config_req_o,
  output logic [CW-1:0]     config_data_o,
  output logic              spi_start_o,
  input  logic              spi_finish_i,
  output logic [DW-1:0]     spi_din_o,
  input  logic [DW-1:0]     spi_dout_i
);

  logic [2:0]       state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [CW-1:0]    cfg_q, cfg_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [N_REQ-1:0] ack_q;
  logic             busy_q, config_req_q, spi_start_q;

  logic             w_found, w_skip;
  logic [IW-1:0]    w_idx;
  logic [CW-1:0]    w_cfg_sel;
  logic [DW-1:0]    w_wdata_sel;

  spi_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req_i    (req_i),
    .rr_ptr_i (rr_ptr_q),
    .found_o  (w_found),
    .idx_o    (w_idx)
  );

  always_comb begin
    w_cfg_sel   = '0;
    w_wdata_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_idx == IW'(i)) begin
        w_cfg_sel   = req_cfg_i[i*CW +: CW];
        w_wdata_sel = req_wdata_i[i*DW +: DW];
      end
    end
  end

`ifdef SPI_ARB_CFG_SKIP_EN
  logic          cfg_valid_q;
  logic [CW-1:0] last_cfg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_valid_q <= 1'b0;
      last_cfg_q  <= '0;
    end else if (state_q == ST_CFG) begin
      cfg_valid_q <= 1'b1;
      last_cfg_q  <= cfg_q;
    end
  end

  assign w_skip = cfg_valid_q && (w_cfg_sel == last_cfg_q);
`else
  assign w_skip = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    cfg_d    = cfg_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (w_found) begin
          grant_d = w_idx;
          cfg_d   = w_cfg_sel;
          wdata_d = w_wdata_sel;
          state_d = w_skip ? ST_START : ST_CFG;
        end
      end
      ST_CFG:    state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_START;
      ST_START:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (spi_finish_i) begin
          rdata_d = spi_dout_i;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        rr_ptr_d = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + IW'(1);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pulse outputs are derived from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      cfg_q        <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      ack_q        <= '0;
      busy_q       <= 1'b0;
      config_req_q <= 1'b0;
      spi_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      cfg_q        <= cfg_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      busy_q       <= (state_d != ST_IDLE);
      config_req_q <= (state_d == ST_CFG);
      spi_start_q  <= (state_d == ST_START);
      ack_q        <= '0;
      if (state_d == ST_DONE) begin
        ack_q[grant_d] <= 1'b1;
      end
    end
  end

  assign ack_o         = ack_q;
  assign rdata_o       = rdata_q;
  assign busy_o        = busy_q;
  assign grant_idx_o   = grant_q;
  assign config_req_o  = config_req_q;
  assign config_data_o = cfg_q;
  assign spi_start_o   = spi_start_q;
  assign spi_din_o     = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_arbiter.sv
// ============================================================
// tb_spi_master_arbiter : directed vector bench for the arbiter
// Rev 1.0
// ============================================================
`default_nettype none

module tb_spi_master_arbiter;

  localparam int N  = 2;
  localparam int L  = 4;
  localparam int CW = 6;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*CW-1:0] req_cfg = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic            grant_idx;
  logic            config_req;
  logic [CW-1:0]   config_data;
  logic            spi_start;
  logic            spi_finish = 1'b0;
  logic [DW-1:0]   spi_din;
  logic [DW-1:0]   spi_dout = '0;

  int n_total = 0;
  int n_pass  = 0;

  spi_master_arbiter #(.N_REQ(N), .SPI_MAX_WIDTH_LOG(L)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req),
    .req_cfg_i     (req_cfg),
    .req_wdata_i   (req_wdata),
    .ack_o         (ack),
    .rdata_o       (rdata),
    .busy_o        (busy),
    .grant_idx_o   (grant_idx),
    .config_req_o  (config_req),
    .config_data_o (config_data),
    .spi_start_o   (spi_start),
    .spi_finish_i  (spi_finish),
    .spi_din_o     (spi_din),
    .spi_dout_i    (spi_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [5:0]  cfg0, cfg1;
    logic [15:0] wd0, wd1;
    int          wait_n;
    logic [15:0] dout;
    int          grant;
    logic [5:0]  ecfg;
    logic [15:0] edin;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_start();
    bit seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (spi_start) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("start_timeout", {31'd0, seen}, 32'd1);
  endtask

  task automatic serve(input int n, input logic [15:0] d,
                       output logic [1:0] a, output logic g, output logic [15:0] r);
    wait_start();
    repeat (n) @(negedge clk);
    spi_finish = 1'b1;
    spi_dout   = d;
    @(negedge clk);
    spi_finish = 1'b0;
    a = ack;
    g = grant_idx;
    r = rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  a;
    logic        g;
    logic [15:0] r;
    int          cnt;

    tbl[0] = '{2'b01, 6'b10_0111, 6'h00, 16'hA55A, 16'h0000, 9, 16'h3C3C, 0, 6'h27, 16'hA55A};
    tbl[1] = '{2'b11, 6'h05, 6'h2F, 16'h1111, 16'h2222, 2, 16'hBEEF, 1, 6'h2F, 16'h2222};
    tbl[2] = '{2'b10, 6'h05, 6'h1A, 16'h1111, 16'hCAFE, 1, 16'h0001, 1, 6'h1A, 16'hCAFE};
    tbl[3] = '{2'b11, 6'h3F, 6'h00, 16'hFFFF, 16'h0000, 4, 16'h8000, 0, 6'h3F, 16'hFFFF};
    tbl[4] = '{2'b01, 6'h11, 6'h00, 16'h1234, 16'h0000, 1, 16'h5678, 0, 6'h11, 16'h1234};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ack", {30'd0, ack}, 32'd0);
    chk("rst_rdata", {16'd0, rdata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_grant", {31'd0, grant_idx}, 32'd0);
    chk("rst_cfg_req", {31'd0, config_req}, 32'd0);
    chk("rst_cfg_data", {26'd0, config_data}, 32'd0);
    chk("rst_start", {31'd0, spi_start}, 32'd0);
    chk("rst_din", {16'd0, spi_din}, 32'd0);

    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      req       = tbl[t].req;
      req_cfg   = {tbl[t].cfg1, tbl[t].cfg0};
      req_wdata = {tbl[t].wd1, tbl[t].wd0};
      @(negedge clk);
      chk("vec_cfg_req", {31'd0, config_req}, 32'd1);
      chk("vec_cfg_data", {26'd0, config_data}, {26'd0, tbl[t].ecfg});
      chk("vec_grant", {31'd0, grant_idx}, tbl[t].grant);
      chk("vec_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("vec_cfg_req_pulse", {31'd0, config_req}, 32'd0);
      @(negedge clk);
      chk("vec_start", {31'd0, spi_start}, 32'd1);
      chk("vec_din", {16'd0, spi_din}, {16'd0, tbl[t].edin});
      repeat (tbl[t].wait_n) @(negedge clk);
      spi_finish = 1'b1;
      spi_dout   = tbl[t].dout;
      @(negedge clk);
      spi_finish = 1'b0;
      chk("vec_ack", {30'd0, ack}, {30'd0, 2'b01 << tbl[t].grant});
      chk("vec_rdata", {16'd0, rdata}, {16'd0, tbl[t].dout});
      req = '0;
      @(negedge clk);
      chk("vec_idle_busy", {31'd0, busy}, 32'd0);
      chk("vec_idle_ack", {30'd0, ack}, 32'd0);
    end

    // Contention with reset-cleared pointer: 0, 1, then 0 again.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req_cfg = {6'h22, 6'h21};
    req_wdata = {16'hBBBB, 16'hAAAA};
    req = 2'b11;
    serve(2, 16'h0A0A, a, g, r);
    chk("rr_first_grant", {31'd0, g}, 32'd0);
    chk("rr_first_ack", {30'd0, a}, 32'd1);
    chk("rr_first_rdata", {16'd0, r}, 32'h0A0A);
    req = 2'b10;
    serve(1, 16'h0B0B, a, g, r);
    chk("rr_second_grant", {31'd0, g}, 32'd1);
    chk("rr_second_ack", {30'd0, a}, 32'd2);
    req = 2'b00;
    @(negedge clk);
    req = 2'b11;
    serve(1, 16'h0C0C, a, g, r);
    chk("rr_wrap_grant", {31'd0, g}, 32'd0);
    chk("rr_wrap_ack", {30'd0, a}, 32'd1);
    req = 2'b00;

    // Spurious finish during SETTLE.
    @(negedge clk);
    req_cfg = {6'h22, 6'h0C};
    req = 2'b01;
    @(negedge clk);
    chk("spur_cfg_req", {31'd0, config_req}, 32'd1);
    @(negedge clk);
    spi_finish = 1'b1;
    spi_dout   = 16'hDEAD;
    @(negedge clk);
    spi_finish = 1'b0;
    chk("spur_start", {31'd0, spi_start}, 32'd1);
    chk("spur_no_ack", {30'd0, ack}, 32'd0);
    @(negedge clk);
    spi_finish = 1'b1;
    spi_dout   = 16'h5A5A;
    @(negedge clk);
    spi_finish = 1'b0;
    chk("spur_ack", {30'd0, ack}, 32'd1);
    chk("spur_rdata", {16'd0, rdata}, 32'h5A5A);
    req = 2'b00;

    // Reset while waiting for finish.
    @(negedge clk);
    req_cfg = {6'h22, 6'h0D};
    req = 2'b01;
    wait_start();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ack", {30'd0, ack}, 32'd0);
    chk("mid_rst_start", {31'd0, spi_start}, 32'd0);
    chk("mid_rst_rdata", {16'd0, rdata}, 32'd0);
    req = 2'b10;
    @(negedge clk);
    chk("post_rst_cfg_req", {31'd0, config_req}, 32'd1);
    chk("post_rst_grant", {31'd0, grant_idx}, 32'd1);
    chk("post_rst_cfg_data", {26'd0, config_data}, 32'h22);
    serve(3, 16'h7777, a, g, r);
    chk("post_rst_ack", {30'd0, a}, 32'd2);
    chk("post_rst_rdata", {16'd0, r}, 32'h7777);
    req = 2'b00;

    // Requester 0 raises and withdraws while requester 1 is in WAIT.
    @(negedge clk);
    req_cfg = {6'h33, 6'h0D};
    req = 2'b10;
    wait_start();
    @(negedge clk);
    req = 2'b11;
    @(negedge clk);
    req = 2'b10;
    spi_finish = 1'b1;
    spi_dout   = 16'h1357;
    @(negedge clk);
    spi_finish = 1'b0;
    chk("wd_ack", {30'd0, ack}, 32'd2);
    req = 2'b00;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack != 2'b00 || busy) cnt++;
    end
    chk("wd_never_served", cnt, 32'd0);

`ifdef SPI_ARB_CFG_SKIP_EN
    @(negedge clk);
    req_cfg = {6'h33, 6'h15};
    req = 2'b01;
    @(negedge clk);
    chk("skip_first_cfg_req", {31'd0, config_req}, 32'd1);
    serve(1, 16'h1111, a, g, r);
    chk("skip_first_ack", {30'd0, a}, 32'd1);
    req = 2'b00;
    @(negedge clk);
    req = 2'b01;
    @(negedge clk);
    chk("skip_second_cfg_req", {31'd0, config_req}, 32'd0);
    chk("skip_second_start", {31'd0, spi_start}, 32'd1);
    serve(1, 16'h2222, a, g, r);
    chk("skip_second_ack", {30'd0, a}, 32'd1);
    req = 2'b00;
    @(negedge clk);
    req_cfg = {6'h33, 6'h16};
    req = 2'b01;
    @(negedge clk);
    chk("skip_changed_cfg_req", {31'd0, config_req}, 32'd1);
    serve(1, 16'h3333, a, g, r);
    chk("skip_changed_ack", {30'd0, a}, 32'd1);
    req = 2'b00;
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
